// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: owner encoding, read-tag type and default widths for the memory arbiter
package mem_port_arbiter_pkg;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_ALG  = 2'd2
    } owner_t;
    typedef struct packed {
        logic valid;
        logic is_vga;
        logic force_zero;
    } tag_t;
endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: latency-matched shift register of read tags, cleared by synchronous active-low reset
module rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 3
)(
    input  logic clock,
    input  logic reset,
    input  tag_t din,
    output tag_t dout
);
    tag_t stage [DEPTH];
    // shift one tag per cycle; clearing drops every in-flight read
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: time-slot sharing of the image memory between VGA fetch and algorithm port
// Optional stall_cnt/vga_miss outputs exist only when MEM_PORT_ARBITER_STATS_EN is defined
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = mem_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W      = mem_port_arbiter_pkg::DATA_W,
    parameter int RD_LAT      = 2,
    parameter int SLOT_PERIOD = 4
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              alg_req,
    input  logic              alg_we,
    input  logic [ADDR_W-1:0] alg_addr,
    input  logic [DATA_W-1:0] alg_wdata,
    output logic              alg_gnt,
    output logic [DATA_W-1:0] alg_rdata,
    output logic              alg_rvalid,
    input  logic              alg_burst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic              vga_miss
`endif
);
    localparam int SW = (SLOT_PERIOD > 1) ? $clog2(SLOT_PERIOD) : 1;
    logic [SW-1:0] slot;
    logic          vga_slot;
    owner_t        owner;
    tag_t          push;
    tag_t          tail;
    // owner decision and tag for the access issued at the coming edge
    always_comb begin
        vga_slot = (slot == '0);
        owner = !reset ? OWN_IDLE :
                (vga_slot && vga_req && !alg_burst) ? OWN_VGA :
                alg_req ? OWN_ALG : OWN_IDLE;
        push.valid = (owner == OWN_VGA) || (owner == OWN_ALG && !alg_we);
        push.is_vga = (owner == OWN_VGA);
        // a ceded VGA slot still owes the display a (black) pixel; this flag rides alongside any ALG read
        push.force_zero = reset && vga_slot && vga_req && alg_burst;
    end
    assign alg_gnt = (owner == OWN_ALG);
    // slot counter and registered memory command
    always_ff @(posedge clock) begin
        if (!reset) begin
            slot     <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
        end else begin
            slot     <= (slot == SW'(SLOT_PERIOD - 1)) ? '0 : slot + SW'(1);
            mem_wren <= (owner == OWN_ALG) && alg_we;
            if (owner == OWN_VGA) begin
                mem_addr <= vga_addr;
            end else if (owner == OWN_ALG) begin
                mem_addr <= alg_addr;
                mem_data <= alg_wdata;
            end
        end
    end
    rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tags (
        .clock(clock),
        .reset(reset),
        .din  (push),
        .dout (tail)
    );
    // steer returning read data to its requester when the matching tag reaches the tail
    always_ff @(posedge clock) begin
        if (!reset) begin
            vga_data   <= '0;
            vga_valid  <= 1'b0;
            alg_rdata  <= '0;
            alg_rvalid <= 1'b0;
        end else begin
            vga_valid  <= (tail.valid && tail.is_vga) || tail.force_zero;
            alg_rvalid <= tail.valid && !tail.is_vga;
            if (tail.force_zero) vga_data <= '0;
            else if (tail.valid && tail.is_vga) vga_data <= mem_q;
            if (tail.valid && !tail.is_vga) alg_rdata <= mem_q;
        end
    end
`ifdef MEM_PORT_ARBITER_STATS_EN
    // saturating count of cycles the algorithm waited, plus forced-black pixel pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= '0;
            vga_miss  <= 1'b0;
        end else begin
            vga_miss <= tail.force_zero;
            if (alg_req && !alg_gnt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus checked against a cycle-scheduled reference model
module tb_mem_port_arbiter;
    localparam int RD_LAT = 2;
    localparam int SP     = 4;
    localparam int LAT    = RD_LAT + 2;

    logic        clock = 0;
    logic        reset = 0;
    logic        vga_req = 0;
    logic [17:0] vga_addr = 0;
    logic [7:0]  vga_data;
    logic        vga_valid;
    logic        alg_req = 0;
    logic        alg_we = 0;
    logic [17:0] alg_addr = 0;
    logic [7:0]  alg_wdata = 0;
    logic        alg_gnt;
    logic [7:0]  alg_rdata;
    logic        alg_rvalid;
    logic        alg_burst = 0;
    logic [17:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  mem_q;
`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [15:0] stall_cnt;
    logic        vga_miss;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .alg_req(alg_req), .alg_we(alg_we), .alg_addr(alg_addr), .alg_wdata(alg_wdata),
        .alg_gnt(alg_gnt), .alg_rdata(alg_rdata), .alg_rvalid(alg_rvalid), .alg_burst(alg_burst),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
`ifdef MEM_PORT_ARBITER_STATS_EN
        , .stall_cnt(stall_cnt), .vga_miss(vga_miss)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h5B;
    endfunction

    // physical memory: RD_LAT output registers, write on the edge after mem_wren
    logic [7:0] store [int];
    logic [7:0] q1, q2;
    assign mem_q = q2;
    always @(posedge clock) begin
        q1 <= store.exists(int'(mem_addr)) ? store[int'(mem_addr)] : init_val(mem_addr);
        q2 <= q1;
        if (mem_wren) store[int'(mem_addr)] = mem_data;
    end

    // reference model: own memory image plus expected return pulses keyed by cycle number
    logic [7:0]  ref_mem [int];
    logic [7:0]  exp_vga [int];
    logic [7:0]  exp_alg [int];
    bit          exp_miss [int];
    int          cyc;
    logic [7:0]  m_vga_data, m_alg_rdata, m_data;
    logic [17:0] m_addr;
    logic        m_wren;
    logic [15:0] m_stall;
    logic        last_gnt;

    function automatic logic [7:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        int  slot;
        bit  own_vga, own_alg, fz;
        #1;
        slot    = cyc % SP;
        own_vga = (slot == 0) && vga_req && !alg_burst;
        own_alg = !own_vga && alg_req;
        fz      = (slot == 0) && vga_req && alg_burst;
        if (exp_vga.exists(cyc)) m_vga_data = exp_vga[cyc];
        if (exp_alg.exists(cyc)) m_alg_rdata = exp_alg[cyc];
        chk("vga_valid", vga_valid, exp_vga.exists(cyc));
        chk("vga_data", vga_data, m_vga_data);
        chk("alg_rvalid", alg_rvalid, exp_alg.exists(cyc));
        chk("alg_rdata", alg_rdata, m_alg_rdata);
        chk("mem_wren", mem_wren, m_wren);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_data);
        chk("alg_gnt", alg_gnt, own_alg);
`ifdef MEM_PORT_ARBITER_STATS_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("vga_miss", vga_miss, exp_miss.exists(cyc));
`endif
        last_gnt = alg_gnt;
        if (own_vga) begin
            m_addr = vga_addr;
            exp_vga[cyc + LAT] = ref_rd(vga_addr);
        end
        if (fz) begin
            exp_vga[cyc + LAT] = 8'h00;
            exp_miss[cyc + LAT] = 1'b1;
        end
        m_wren = own_alg && alg_we;
        if (own_alg) begin
            m_addr = alg_addr;
            m_data = alg_wdata;
            if (alg_we) ref_mem[int'(alg_addr)] = alg_wdata;
            else exp_alg[cyc + LAT] = ref_rd(alg_addr);
        end
        if (alg_req && !own_alg && m_stall != 16'hFFFF) m_stall++;
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 0;
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            chk("rst_vga_valid", vga_valid, 0);
            chk("rst_vga_data", vga_data, 0);
            chk("rst_alg_rvalid", alg_rvalid, 0);
            chk("rst_alg_rdata", alg_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_data", mem_data, 0);
            chk("rst_mem_wren", mem_wren, 0);
            chk("rst_alg_gnt", alg_gnt, 0);
`ifdef MEM_PORT_ARBITER_STATS_EN
            chk("rst_stall_cnt", stall_cnt, 0);
`endif
        end
        exp_vga.delete();
        exp_alg.delete();
        exp_miss.delete();
        cyc = 0;
        m_vga_data = 0; m_alg_rdata = 0; m_data = 0; m_addr = 0; m_wren = 0; m_stall = 0;
        reset = 1;
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        last_gnt = 0;
        while (!last_gnt && n < 8) begin
            tick();
            n++;
        end
        chk(tag, last_gnt, 1);
    endtask

    initial begin
        // VGA alone: one read per period at slot 0
        vga_req = 1; vga_addr = 18'h00100;
        do_reset(3);
        repeat (12) tick();
        // algorithm reads fill slots 1..3
        alg_req = 1; alg_we = 0; alg_addr = 18'h12C00;
        repeat (12) tick();
        // write then read back the same address
        alg_we = 1; alg_addr = 18'h00005; alg_wdata = 8'hC3;
        wait_gnt("write_grant");
        alg_we = 0; alg_wdata = 8'h00;
        wait_gnt("readback_grant");
        alg_req = 0;
        repeat (6) tick();
        // burst: algorithm owns every slot, VGA receives black pixels
        vga_addr = 18'h3FFFF; alg_burst = 1; alg_req = 1; alg_addr = 18'h00005;
        repeat (12) tick();
        // reset one cycle after an algorithm read grant
        alg_burst = 0; vga_req = 0; alg_addr = 18'h00ABC;
        wait_gnt("pre_reset_grant");
        do_reset(3);
        vga_req = 1; vga_addr = 18'h00100; alg_req = 1; alg_addr = 18'h00007;
        repeat (12) tick();
`ifdef MEM_PORT_ARBITER_STATS_EN
        chk("stall_cnt_after_3_vga_wins", stall_cnt, 3);
`endif
        // randomized traffic
        alg_req = 0;
        for (int i = 0; i < 400; i++) begin
            vga_req  = ($urandom_range(3) != 0);
            vga_addr = 18'($urandom_range(15));
            if (($urandom_range(15)) == 0) alg_burst = ~alg_burst;
            if (!(alg_req && !last_gnt && $urandom_range(9) != 0)) begin
                alg_req   = ($urandom_range(3) != 0);
                alg_we    = ($urandom_range(2) == 0);
                alg_addr  = 18'($urandom_range(15));
                alg_wdata = 8'($urandom);
            end
            tick();
        end
        alg_req = 0; vga_req = 0;
        repeat (6) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
